// File: rtl/envelope_control.sv
// rtl/envelope_control.sv - PSG envelope register front-end and restart sequencer
// Holds period/shape registers and keeps env_restart high until the envelope's own step edge.
module envelope_control #(
  parameter int PERIOD_BITS  = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [3:0]             wr_addr,
  input  logic [7:0]             wr_data,
  input  logic                   env_tick,
  output logic [PERIOD_BITS-1:0] env_period,
  output logic                   env_continue,
  output logic                   env_attack,
  output logic                   env_alternate,
  output logic                   env_hold,
  output logic                   env_restart,
  output logic                   busy,
  output logic                   restart_timeout
);

  localparam int HI_BITS = PERIOD_BITS - 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    tick_q;
  logic [PERIOD_BITS-1:0]  shadow_q, shadow_d;
  logic [PERIOD_BITS-1:0]  period_q, period_d;
  logic                    pending_q, pending_d;
  logic [3:0]              shape_q, shape_d;
  logic [TIMEOUT_BITS-1:0] wdog_q, wdog_d;
  logic                    restart_q, restart_d;
  logic                    busy_q, busy_d;
  logic                    timeout_q, timeout_d;

  logic wr_lo, wr_hi, wr_shape, tick_rise, arm_entry, commit;

  always_comb begin
    wr_lo     = wr_en && (wr_addr == 4'd11);
    wr_hi     = wr_en && (wr_addr == 4'd12);
    wr_shape  = wr_en && (wr_addr == 4'd13);
    tick_rise = env_tick & ~tick_q;

    state_d   = state_q;
    wdog_d    = wdog_q;
    timeout_d = timeout_q;

    case (state_q)
      S_IDLE: begin
        // A tick edge on the write clock is deliberately not honoured here.
        if (wr_shape) begin
          state_d = S_ARM;
          wdog_d  = '0;
        end
      end
      S_ARM: begin
        if (wr_shape) begin
          wdog_d = '0;
        end else if (tick_rise) begin
          state_d = S_RELEASE;
        end else if (&wdog_q) begin
          state_d   = S_RELEASE;
          timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + TIMEOUT_BITS'(1);
        end
      end
      S_RELEASE: begin
        if (wr_shape) begin
          state_d = S_ARM;
          wdog_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Shadow equals the committed period whenever nothing is pending, so gating is lossless.
    arm_entry = (state_q != S_ARM) && (state_d == S_ARM);
    commit    = pending_q && (tick_rise || arm_entry);
    period_d  = commit ? shadow_q : period_q;

    shadow_d = shadow_q;
    if (wr_lo) shadow_d[7:0] = wr_data;
    if (wr_hi) shadow_d[PERIOD_BITS-1:8] = HI_BITS'(wr_data);
    pending_d = (pending_q && !commit) || wr_lo || wr_hi;

    shape_d   = wr_shape ? wr_data[3:0] : shape_q;
    restart_d = (state_d != S_IDLE);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tick_q    <= 1'b0;
      shadow_q  <= '0;
      period_q  <= '0;
      pending_q <= 1'b0;
      shape_q   <= 4'h0;
      wdog_q    <= '0;
      restart_q <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= env_tick;
      shadow_q  <= shadow_d;
      period_q  <= period_d;
      pending_q <= pending_d;
      shape_q   <= shape_d;
      wdog_q    <= wdog_d;
      restart_q <= restart_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign env_period      = period_q;
  assign env_continue    = shape_q[3];
  assign env_attack      = shape_q[2];
  assign env_alternate   = shape_q[1];
  assign env_hold        = shape_q[0];
  assign env_restart     = restart_q;
  assign busy            = busy_q;
  assign restart_timeout = timeout_q;

endmodule

// File: tb/tb_envelope_control.sv
// tb/tb_envelope_control.sv - self-checking bench for envelope_control
// Vector table, directed corner sequences, then random traffic against a reference model.
module tb_envelope_control;

  localparam int TB_TO     = 4;
  localparam int ARM_LIMIT = 1 << TB_TO;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = 4'd0;
  logic [7:0]  wr_data = 8'd0;
  logic        env_tick = 1'b0;
  logic [15:0] env_period;
  logic        env_continue, env_attack, env_alternate, env_hold;
  logic        env_restart, busy, restart_timeout;

  int checks = 0;
  int errors = 0;

  envelope_control #(.PERIOD_BITS(16), .TIMEOUT_BITS(TB_TO)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .env_tick(env_tick), .env_period(env_period), .env_continue(env_continue),
    .env_attack(env_attack), .env_alternate(env_alternate), .env_hold(env_hold),
    .env_restart(env_restart), .busy(busy), .restart_timeout(restart_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic        tick;
    logic [15:0] period;
    logic [3:0]  shape;
    logic        restart;
  } vec_t;

  vec_t tbl [31];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic we, input logic [3:0] addr, input logic [7:0] data, input logic tick);
    wr_en = we; wr_addr = addr; wr_data = data; env_tick = tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] shape_now();
    return {env_continue, env_attack, env_alternate, env_hold};
  endfunction

  // Reference model: phase 0 idle, 1 waiting for the envelope edge, 2 releasing.
  int          m_phase;
  int          m_armed_for;
  logic [15:0] m_period, m_shadow;
  logic [3:0]  m_shape;
  logic        m_to, m_tick_prev;

  task automatic model_reset();
    m_phase = 0; m_armed_for = 0; m_period = 16'h0; m_shadow = 16'h0;
    m_shape = 4'h0; m_to = 1'b0; m_tick_prev = 1'b0;
  endtask

  task automatic model_step(input logic we, input logic [3:0] addr, input logic [7:0] data, input logic tick);
    logic rise, shp;
    rise = tick && !m_tick_prev;
    shp  = we && (addr == 4'd13);
    if (rise || (shp && m_phase != 1)) m_period = m_shadow;
    if (we && addr == 4'd11) m_shadow[7:0] = data;
    if (we && addr == 4'd12) m_shadow[15:8] = data;
    if (shp) m_shape = data[3:0];
    case (m_phase)
      0: if (shp) begin m_phase = 1; m_armed_for = 1; end
      1: begin
        if (shp) m_armed_for = 1;
        else if (rise) m_phase = 2;
        else if (m_armed_for == ARM_LIMIT) begin m_phase = 2; m_to = 1'b1; end
        else m_armed_for = m_armed_for + 1;
      end
      default: if (shp) begin m_phase = 1; m_armed_for = 1; end else m_phase = 0;
    endcase
    m_tick_prev = tick;
  endtask

  initial begin
    int n;
    logic tk;
    logic we;
    logic [3:0] ad;
    logic [7:0] dt;

    tbl[0]  = '{1'b1, 4'd11, 8'h34, 1'b0, 16'h0000, 4'h0, 1'b0};
    tbl[1]  = '{1'b1, 4'd12, 8'h12, 1'b0, 16'h0000, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 4'd0,  8'h00, 1'b0, 16'h0000, 4'h0, 1'b0};
    tbl[3]  = '{1'b0, 4'd0,  8'h00, 1'b1, 16'h1234, 4'h0, 1'b0};
    tbl[4]  = '{1'b0, 4'd0,  8'h00, 1'b1, 16'h1234, 4'h0, 1'b0};
    tbl[5]  = '{1'b0, 4'd0,  8'h00, 1'b0, 16'h1234, 4'h0, 1'b0};
    tbl[6]  = '{1'b1, 4'd13, 8'hFE, 1'b0, 16'h1234, 4'hE, 1'b1};
    for (int i = 7; i <= 12; i++) tbl[i] = '{1'b0, 4'd0, 8'h00, 1'b0, 16'h1234, 4'hE, 1'b1};
    tbl[13] = '{1'b0, 4'd0,  8'h00, 1'b1, 16'h1234, 4'hE, 1'b1};
    tbl[14] = '{1'b0, 4'd0,  8'h00, 1'b1, 16'h1234, 4'hE, 1'b0};
    tbl[15] = '{1'b0, 4'd0,  8'h00, 1'b0, 16'h1234, 4'hE, 1'b0};
    tbl[16] = '{1'b1, 4'd13, 8'hFE, 1'b0, 16'h1234, 4'hE, 1'b1};
    tbl[17] = '{1'b0, 4'd0,  8'h00, 1'b0, 16'h1234, 4'hE, 1'b1};
    tbl[18] = '{1'b0, 4'd0,  8'h00, 1'b0, 16'h1234, 4'hE, 1'b1};
    tbl[19] = '{1'b0, 4'd0,  8'h00, 1'b0, 16'h1234, 4'hE, 1'b1};
    tbl[20] = '{1'b1, 4'd13, 8'h09, 1'b0, 16'h1234, 4'h9, 1'b1};
    tbl[21] = '{1'b0, 4'd0,  8'h00, 1'b1, 16'h1234, 4'h9, 1'b1};
    tbl[22] = '{1'b0, 4'd0,  8'h00, 1'b0, 16'h1234, 4'h9, 1'b0};
    tbl[23] = '{1'b0, 4'd0,  8'h00, 1'b0, 16'h1234, 4'h9, 1'b0};
    tbl[24] = '{1'b1, 4'd13, 8'h05, 1'b1, 16'h1234, 4'h5, 1'b1};
    tbl[25] = '{1'b0, 4'd0,  8'h00, 1'b0, 16'h1234, 4'h5, 1'b1};
    tbl[26] = '{1'b0, 4'd0,  8'h00, 1'b1, 16'h1234, 4'h5, 1'b1};
    tbl[27] = '{1'b0, 4'd0,  8'h00, 1'b0, 16'h1234, 4'h5, 1'b0};
    tbl[28] = '{1'b1, 4'd14, 8'hFF, 1'b0, 16'h1234, 4'h5, 1'b0};
    tbl[29] = '{1'b0, 4'd0,  8'h00, 1'b1, 16'h1234, 4'h5, 1'b0};
    tbl[30] = '{1'b0, 4'd0,  8'h00, 1'b0, 16'h1234, 4'h5, 1'b0};

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_period", 32'(env_period), 32'h0);
    chk("rst_shape", 32'(shape_now()), 32'h0);
    chk("rst_restart", 32'(env_restart), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_timeout", 32'(restart_timeout), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 31; i++) begin
      cycle(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].tick);
      chk($sformatf("vec%0d_period", i), 32'(env_period), 32'(tbl[i].period));
      chk($sformatf("vec%0d_shape", i), 32'(shape_now()), 32'(tbl[i].shape));
      chk($sformatf("vec%0d_restart", i), 32'(env_restart), 32'(tbl[i].restart));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].restart));
    end

    // Watchdog: re-arm mid-wait, then expect a full 16 clocks before release.
    chk("timeout_pre", 32'(restart_timeout), 32'h0);
    cycle(1'b1, 4'd13, 8'h0A, 1'b0);
    chk("wd_arm", 32'(env_restart), 32'h1);
    repeat (5) cycle(1'b0, 4'd0, 8'h00, 1'b0);
    cycle(1'b1, 4'd13, 8'h0B, 1'b0);
    chk("wd_rearm_shape", 32'(shape_now()), 32'hB);
    n = 0;
    do begin
      cycle(1'b0, 4'd0, 8'h00, 1'b0);
      n++;
    end while (!restart_timeout && n < 64);
    chk("wd_cycles", 32'(n), 32'd16);
    chk("wd_release_restart", 32'(env_restart), 32'h1);
    cycle(1'b0, 4'd0, 8'h00, 1'b0);
    chk("wd_idle_restart", 32'(env_restart), 32'h0);
    chk("wd_idle_busy", 32'(busy), 32'h0);
    cycle(1'b0, 4'd0, 8'h00, 1'b1);
    cycle(1'b0, 4'd0, 8'h00, 1'b0);
    chk("wd_sticky", 32'(restart_timeout), 32'h1);

    // Write colliding with the commit edge lands in shadow for the next edge.
    cycle(1'b1, 4'd11, 8'h10, 1'b0);
    cycle(1'b1, 4'd12, 8'h00, 1'b0);
    cycle(1'b0, 4'd0, 8'h00, 1'b0);
    chk("col_hold", 32'(env_period), 32'h1234);
    cycle(1'b1, 4'd12, 8'hAB, 1'b1);
    chk("col_commit_old", 32'(env_period), 32'h0010);
    cycle(1'b0, 4'd0, 8'h00, 1'b0);
    chk("col_stable", 32'(env_period), 32'h0010);
    cycle(1'b0, 4'd0, 8'h00, 1'b1);
    chk("col_commit_new", 32'(env_period), 32'hAB10);
    cycle(1'b0, 4'd0, 8'h00, 1'b0);

    // Asynchronous reset mid-handshake.
    cycle(1'b1, 4'd13, 8'h07, 1'b0);
    chk("ar_armed", 32'(env_restart), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("ar_restart", 32'(env_restart), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_period", 32'(env_period), 32'h0);
    chk("ar_shape", 32'(shape_now()), 32'h0);
    chk("ar_timeout", 32'(restart_timeout), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 4'd0, 8'h00, 1'(i % 3 == 0));
      if (env_restart || busy) n++;
    end
    chk("ar_no_spurious", 32'(n), 32'h0);

    // Random traffic against the reference model.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    tk = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      we = ($urandom % 3) == 0;
      case ($urandom % 4)
        0: ad = 4'd11;
        1: ad = 4'd12;
        2: ad = 4'd13;
        default: ad = 4'($urandom_range(0, 15));
      endcase
      dt = 8'($urandom);
      if ($urandom % 4 == 0) tk = ~tk;
      model_step(we, ad, dt, tk);
      cycle(we, ad, dt, tk);
      chk("rnd_period", 32'(env_period), 32'(m_period));
      chk("rnd_shape", 32'(shape_now()), 32'(m_shape));
      chk("rnd_restart", 32'(env_restart), 32'(m_phase != 0));
      chk("rnd_busy", 32'(busy), 32'(m_phase != 0));
      chk("rnd_timeout", 32'(restart_timeout), 32'(m_to));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
